// File: rtl/myhistory_if.sv
// myhistory_if: sample handshake in, sign-extended term history and status out
interface myhistory_if #(parameter int in_bits = 8, n_terms = 4, out_bits = 10);
    logic signed [in_bits-1:0] in_data;
    logic in_valid, in_ready, flush;
    logic signed [out_bits-1:0] out [n_terms];
    logic out_valid, out_update;
    logic [$clog2(n_terms+1)-1:0] fill;
    modport master (output in_data, in_valid, flush, input in_ready, out, out_valid, out_update, fill);
    modport slave (input in_data, in_valid, flush, output in_ready, out, out_valid, out_update, fill);
endinterface

// File: rtl/myhistory.sv
// myhistory: n_terms-deep sign-extended sample history for the summer, newest in out[0]
module myhistory #(parameter int in_bits = 8, n_terms = 4, out_bits = 10) (
    input logic clk,
    input logic rst_n,
    myhistory_if.slave bus
);
    localparam int fw = $clog2(n_terms + 1);
    localparam logic [fw-1:0] full = fw'(n_terms);
    if (out_bits < in_bits) begin : g_bad_width
        $error("myhistory: out_bits must be >= in_bits");
    end
    if (n_terms < 1) begin : g_bad_depth
        $error("myhistory: n_terms must be >= 1");
    end
    logic acc;
    logic [fw-1:0] nfill;
    assign bus.in_ready = !bus.flush;
    assign acc = bus.in_valid && !bus.flush;
    assign nfill = (bus.fill == full) ? bus.fill : bus.fill + fw'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.flush) begin
            for (int k = 0; k < n_terms; k++) bus.out[k] <= '0;
            bus.fill <= '0;
            bus.out_valid <= 1'b0;
            bus.out_update <= 1'b0;
        end else if (acc) begin
            bus.out[0] <= out_bits'(bus.in_data);
            for (int k = 1; k < n_terms; k++) bus.out[k] <= bus.out[k-1];
            bus.fill <= nfill;
            bus.out_valid <= nfill == full;
            bus.out_update <= nfill == full;
        end else begin
            bus.out_update <= 1'b0;
        end
    end
endmodule

// File: tb/tb_myhistory.sv
// tb_myhistory: randomized + directed check of depth-4 and depth-1 builds against a queue model
module tb_myhistory;
    logic clk = 0, rst_n = 0;
    logic signed [7:0] in_data = 0;
    logic in_valid = 0, flush = 0;
    int checks = 0, errors = 0;
    int q[2][$];
    bit u[2];
    int dep[2] = '{4, 1};

    always #5 clk = ~clk;

    myhistory_if #(.in_bits(8), .n_terms(4), .out_bits(10)) ia ();
    myhistory_if #(.in_bits(8), .n_terms(1), .out_bits(10)) ib ();
    assign ia.in_data = in_data;
    assign ia.in_valid = in_valid;
    assign ia.flush = flush;
    assign ib.in_data = in_data;
    assign ib.in_valid = in_valid;
    assign ib.flush = flush;

    myhistory #(.in_bits(8), .n_terms(4), .out_bits(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    myhistory #(.in_bits(8), .n_terms(1), .out_bits(10)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: newest-first queue capped at depth; fill is simply its size.
    always @(negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            q[i] = {};
            u[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            u[i] = 0;
            if (rst_n && flush) q[i] = {};
            else if (rst_n && in_valid) begin
                q[i].push_front(int'(in_data));
                if (q[i].size() > dep[i]) void'(q[i].pop_back());
                u[i] = q[i].size() == dep[i];
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < dep[i]; k++)
                chk($sformatf("out%0d[%0d]", i, k), i == 0 ? int'(ia.out[k]) : int'(ib.out[0]),
                    k < q[i].size() ? q[i][k] : 0);
            chk($sformatf("fill%0d", i), i == 0 ? int'(ia.fill) : int'(ib.fill), q[i].size());
            chk($sformatf("out_valid%0d", i), i == 0 ? int'(ia.out_valid) : int'(ib.out_valid),
                int'(q[i].size() == dep[i]));
            chk($sformatf("out_update%0d", i), i == 0 ? int'(ia.out_update) : int'(ib.out_update), int'(u[i]));
        end
        chk("in_ready", int'(ia.in_ready), int'(!flush));
    end

    task automatic step(input bit v, input int d, input bit f);
        @(negedge clk);
        in_valid = v;
        in_data = 8'(d);
        flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_fill", int'(ia.fill), 0);
        chk("rst_valid", int'(ia.out_valid), 0);
        chk("rst_ready", int'(ia.in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 1; i <= 4; i++) begin
            step(1, i, 0);
            chk("dir_fill", int'(ia.fill), i);
            chk("dir_upd", int'(ia.out_update), int'(i == 4));
        end
        chk("dir_o0", int'(ia.out[0]), 4);
        chk("dir_o3", int'(ia.out[3]), 1);
        step(1, 5, 0);
        chk("dir_upd5", int'(ia.out_update), 1);
        step(1, -6, 0);
        chk("dir_upd6", int'(ia.out_update), 1);
        chk("dir_raw_m6", int'(ia.out[0][9:0]), 10'h3FA);
        chk("dir_o1", int'(ia.out[1]), 5);
        chk("dir_o3b", int'(ia.out[3]), 3);
        repeat (3) step(0, 0, 0);
        chk("idle_upd", int'(ia.out_update), 0);
        chk("idle_valid", int'(ia.out_valid), 1);
        chk("idle_o0", int'(ia.out[0]), -6);
        @(negedge clk);
        in_valid = 1;
        in_data = 7;
        flush = 1;
        #1;
        chk("flush_ready", int'(ia.in_ready), 0);
        @(posedge clk);
        #1;
        chk("flush_fill", int'(ia.fill), 0);
        chk("flush_o0", int'(ia.out[0]), 0);
        step(1, 7, 0);
        chk("held_o0", int'(ia.out[0]), 7);
        chk("held_fill", int'(ia.fill), 1);
        chk("b_valid", int'(ib.out_valid), 1);
        chk("b_upd", int'(ib.out_update), 1);
        repeat (3) step(1, 9, 0);
        step(0, 0, 0);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_fill", int'(ia.fill), 0);
        chk("arst_valid", int'(ia.out_valid), 0);
        chk("arst_o3", int'(ia.out[3]), 0);
        @(negedge clk);
        rst_n = 1;
        step(1, -128, 0);
        chk("m128_raw", int'(ia.out[0][9:0]), 10'h380);
        chk("m128_fill", int'(ia.fill), 1);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            in_valid = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            in_data = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 0;
                #1 rst_n = 1;
            end
        end
        step(0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
